axi_sram_bridge: RTL and testbench

Converts the core's two SRAM-like request/response ports (instruction fetch and data access, req/addr_ok/data_ok protocol) into a single AXI3 master interface. It sits directly downstream of the CPU core and upstream of the AXI interconnect. It arbitrates reads between the two ports, serialises writes, and routes responses back by AXI ID.

---
 rtl/axi_sram_bridge.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi_sram_bridge.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_bridge.sv
// Bridges the core's inst/data SRAM-like ports onto one AXI3 master: single-beat reads, one write at a time.
// Read: accept T, AR from T+1, data_ok on matching R. Write: accept T, AW/W from T+1, data_ok on B. Refused requests retry.
module axi_sram_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic {AR_IDLE, AR_REQ} ar_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        is_data;
    } rd_req_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] dat;
    } wr_req_t;

    ar_state_t ar_state;
    w_state_t  w_state;
    rd_req_t   rd_q;
    wr_req_t   wr_q;

    logic ar_vld_q;
    logic aw_vld_q;
    logic w_vld_q;
    logic b_rdy_q;
    logic inst_rd_pend;
    logic data_rd_pend;

    logic rd_slot_free;
    logic data_rd_acc;
    logic inst_rd_acc;
    logic data_wr_acc;
    logic r_inst_hit;
    logic r_data_hit;
    logic b_hit;

    // Response status and the inst port's write fields carry nothing this bridge acts on.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                             rresp, rlast, bid, bresp};

    assign rd_slot_free = (ar_state == AR_IDLE) && (w_state == W_IDLE);
    assign data_rd_acc  = resetn && data_sram_req && !data_sram_wr && !data_rd_pend && rd_slot_free;
    assign inst_rd_acc  = resetn && inst_sram_req && !inst_rd_pend && rd_slot_free && !data_rd_acc;
    // A data read still waiting in AR_REQ would otherwise be overtaken by the write.
    assign data_wr_acc  = resetn && data_sram_req && data_sram_wr && (w_state == W_IDLE)
                          && !data_rd_pend && !((ar_state == AR_REQ) && rd_q.is_data);

    assign r_inst_hit = rvalid && (rid == INST_ID) && inst_rd_pend;
    assign r_data_hit = rvalid && (rid == DATA_ID) && data_rd_pend;
    assign b_hit      = (w_state == W_RESP) && bvalid;

    assign inst_sram_addr_ok = inst_rd_acc;
    assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
    assign inst_sram_data_ok = resetn && r_inst_hit;
    assign data_sram_data_ok = resetn && (r_data_hit || b_hit);
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign arid    = rd_q.is_data ? DATA_ID : INST_ID;
    assign araddr  = rd_q.addr;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, rd_q.size};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = ar_vld_q;
    assign rready  = 1'b1;

    assign awid    = DATA_ID;
    assign awaddr  = wr_q.addr;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, wr_q.size};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = aw_vld_q;

    assign wid     = DATA_ID;
    assign wdata   = wr_q.dat;
    assign wstrb   = wr_q.strb;
    assign wlast   = 1'b1;
    assign wvalid  = w_vld_q;
    assign bready  = b_rdy_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_state     <= AR_IDLE;
            ar_vld_q     <= 1'b0;
            rd_q         <= '0;
            inst_rd_pend <= 1'b0;
            data_rd_pend <= 1'b0;
        end else begin
            if (r_inst_hit) inst_rd_pend <= 1'b0;
            if (r_data_hit) data_rd_pend <= 1'b0;
            case (ar_state)
                AR_IDLE: begin
                    if (data_rd_acc || inst_rd_acc) begin
                        ar_state     <= AR_REQ;
                        ar_vld_q     <= 1'b1;
                        rd_q.is_data <= data_rd_acc;
                        rd_q.addr    <= data_rd_acc ? data_sram_addr : inst_sram_addr;
                        rd_q.size    <= data_rd_acc ? data_sram_size : inst_sram_size;
                    end
                end
                AR_REQ: begin
                    if (arready) begin
                        ar_state <= AR_IDLE;
                        ar_vld_q <= 1'b0;
                        if (rd_q.is_data) data_rd_pend <= 1'b1;
                        else              inst_rd_pend <= 1'b1;
                    end
                end
                default: begin
                    ar_state <= AR_IDLE;
                    ar_vld_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state  <= W_IDLE;
            wr_q     <= '0;
            aw_vld_q <= 1'b0;
            w_vld_q  <= 1'b0;
            b_rdy_q  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (data_wr_acc) begin
                        w_state   <= W_SEND;
                        wr_q.addr <= data_sram_addr;
                        wr_q.size <= data_sram_size;
                        wr_q.strb <= data_sram_wstrb;
                        wr_q.dat  <= data_sram_wdata;
                        aw_vld_q  <= 1'b1;
                        w_vld_q   <= 1'b1;
                    end
                end
                W_SEND: begin
                    // AW and W complete independently; either may already be done.
                    if (awready) aw_vld_q <= 1'b0;
                    if (wready)  w_vld_q  <= 1'b0;
                    if ((!aw_vld_q || awready) && (!w_vld_q || wready)) begin
                        w_state <= W_RESP;
                        b_rdy_q <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        w_state <= W_IDLE;
                        b_rdy_q <= 1'b0;
                    end
                end
                default: begin
                    w_state  <= W_IDLE;
                    aw_vld_q <= 1'b0;
                    w_vld_q  <= 1'b0;
                    b_rdy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Directed + randomized bench for axi_sram_bridge; the bench acts as AXI slave and
// compares a request-side memory model against the memory built from AXI traffic.
module tb_axi_sram_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_sram_req = 1'b0, inst_sram_wr = 1'b0;
    logic [1:0]  inst_sram_size = '0;
    logic [3:0]  inst_sram_wstrb = '0;
    logic [31:0] inst_sram_addr = '0, inst_sram_wdata = '0;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req = 1'b0, data_sram_wr = 1'b0;
    logic [1:0]  data_sram_size = '0;
    logic [3:0]  data_sram_wstrb = '0;
    logic [31:0] data_sram_addr = '0, data_sram_wdata = '0;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid, awid, wid, arcache, awcache;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock;
    logic        arvalid, awvalid, wvalid, wlast, rready, bready;
    logic [3:0]  wstrb;
    logic        arready = 1'b0, awready = 1'b0, wready = 1'b0;
    logic [3:0]  rid = '0, bid = '0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0, bresp = '0;
    logic        rlast = 1'b1, rvalid = 1'b0, bvalid = 1'b0;

    axi_sram_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];
    logic [31:0] ia, da, r0, r1, wd, ra;
    logic [3:0]  wi, ws;
    logic [1:0]  wsz, woff;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input logic [3:0] st, input logic [31:0] d);
        logic aw_done, w_done;
        logic [3:0] aw_idx, cap_strb;
        logic [31:0] cap_dat;
        int n, bdel;
        cyc();
        data_sram_req = 1; data_sram_wr = 1; data_sram_size = sz;
        data_sram_wstrb = st; data_sram_addr = a; data_sram_wdata = d;
        #1 chk("wr_accept", 32'(data_sram_addr_ok), 1);
        for (int i = 0; i < 4; i++)
            if (st[i]) ref_mem[a[5:2]][i*8 +: 8] = d[i*8 +: 8];
        cyc();
        data_sram_req = 0; data_sram_wr = 0;
        aw_done = 0; w_done = 0; n = 0; aw_idx = '0; cap_strb = '0; cap_dat = '0;
        while (!(aw_done && w_done) && n < 20) begin
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            #1;
            chk("wr_awvalid_hold", 32'(awvalid), 32'(!aw_done));
            chk("wr_wvalid_hold", 32'(wvalid), 32'(!w_done));
            if (awvalid && awready) begin
                aw_done = 1;
                chk("wr_awaddr", awaddr, a);
                chk("wr_awsize", 32'(awsize), 32'({1'b0, sz}));
                aw_idx = awaddr[5:2];
            end
            if (wvalid && wready) begin
                w_done = 1;
                cap_strb = wstrb;
                cap_dat = wdata;
            end
            n++;
            cyc();
        end
        awready = 0; wready = 0;
        chk("wr_handshakes_done", 32'({aw_done, w_done}), 3);
        for (int i = 0; i < 4; i++)
            if (cap_strb[i]) slv_mem[aw_idx][i*8 +: 8] = cap_dat[i*8 +: 8];
        bdel = $urandom_range(0, 2);
        for (int k = 0; k < bdel; k++) begin
            #1;
            chk("wr_bready", 32'(bready), 1);
            chk("wr_no_early_ok", 32'(data_sram_data_ok), 0);
            cyc();
        end
        bvalid = 1; bid = 4'd1;
        #1 chk("wr_b_data_ok", 32'(data_sram_data_ok), 1);
        cyc();
        bvalid = 0;
    endtask

    task automatic do_read(input logic is_inst, input logic [31:0] a);
        logic hs;
        logic [3:0] idx;
        int n, rdel;
        cyc();
        if (is_inst) begin
            inst_sram_req = 1; inst_sram_addr = a; inst_sram_size = 2;
        end else begin
            data_sram_req = 1; data_sram_wr = 0; data_sram_addr = a; data_sram_size = 2;
        end
        #1 chk("rd_accept", 32'(is_inst ? inst_sram_addr_ok : data_sram_addr_ok), 1);
        cyc();
        inst_sram_req = 0; data_sram_req = 0;
        hs = 0; n = 0; idx = '0;
        while (!hs && n < 10) begin
            arready = 1'($urandom_range(0, 1));
            #1 chk("rd_arvalid", 32'(arvalid), 1);
            if (arvalid && arready) begin
                hs = 1;
                chk("rd_araddr", araddr, a);
                chk("rd_arid", 32'(arid), is_inst ? 0 : 1);
                idx = araddr[5:2];
            end
            n++;
            cyc();
        end
        arready = 0;
        chk("rd_ar_done", 32'(hs), 1);
        rdel = $urandom_range(0, 2);
        for (int k = 0; k < rdel; k++) begin
            #1 chk("rd_no_early_ok", 32'({inst_sram_data_ok, data_sram_data_ok}), 0);
            cyc();
        end
        rvalid = 1; rid = is_inst ? 4'd0 : 4'd1; rdata = slv_mem[idx];
        #1;
        chk("rd_ok_routed", 32'({inst_sram_data_ok, data_sram_data_ok}), is_inst ? 2 : 1);
        chk("rd_data", is_inst ? inst_sram_rdata : data_sram_rdata, ref_mem[a[5:2]]);
        cyc();
        rvalid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, with a request held to prove addr_ok is gated.
        inst_sram_req = 1; inst_sram_addr = 32'h1c000000;
        #2;
        chk("rst_arvalid", 32'(arvalid), 0);
        chk("rst_awvalid", 32'(awvalid), 0);
        chk("rst_wvalid", 32'(wvalid), 0);
        chk("rst_bready", 32'(bready), 0);
        chk("rst_rready", 32'(rready), 1);
        chk("rst_addr_ok", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 0);
        chk("rst_data_ok", 32'({inst_sram_data_ok, data_sram_data_ok}), 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        cyc();
        inst_sram_req = 0;
        cyc();
        resetn = 1;

        // Fetch at 0x1c000000, R three cycles after AR.
        cyc();
        inst_sram_req = 1; inst_sram_addr = 32'h1c000000; inst_sram_size = 2;
        #1 chk("t1_inst_addr_ok", 32'(inst_sram_addr_ok), 1);
        chk("t1_data_addr_ok", 32'(data_sram_addr_ok), 0);
        cyc();
        inst_sram_req = 0; arready = 1;
        #1 chk("t1_arvalid", 32'(arvalid), 1);
        chk("t1_arid", 32'(arid), 0);
        chk("t1_araddr", araddr, 32'h1c000000);
        chk("t1_arsize", 32'(arsize), 2);
        chk("t1_arlen", 32'(arlen), 0);
        chk("t1_arburst", 32'(arburst), 1);
        cyc();
        arready = 0;
        #1 chk("t1_arvalid_drop", 32'(arvalid), 0);
        chk("t1_no_early_ok", 32'(inst_sram_data_ok), 0);
        cyc();
        cyc();
        rvalid = 1; rid = 0; rdata = 32'h02800c0c;
        #1 chk("t1_inst_data_ok", 32'(inst_sram_data_ok), 1);
        chk("t1_inst_rdata", inst_sram_rdata, 32'h02800c0c);
        chk("t1_data_data_ok", 32'(data_sram_data_ok), 0);
        cyc();
        rvalid = 0;

        // Simultaneous reads: data wins, responses return reversed.
        ia = {$urandom} & 32'hfffffffc; da = {$urandom} & 32'hfffffffc;
        r0 = $urandom; r1 = $urandom;
        cyc();
        inst_sram_req = 1; inst_sram_addr = ia; inst_sram_size = 2;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = da; data_sram_size = 2;
        #1 chk("t2_data_wins", 32'(data_sram_addr_ok), 1);
        chk("t2_inst_loses", 32'(inst_sram_addr_ok), 0);
        cyc();
        data_sram_req = 0; arready = 1;
        #1 chk("t2_ar1_arid", 32'(arid), 1);
        chk("t2_ar1_araddr", araddr, da);
        chk("t2_inst_blocked", 32'(inst_sram_addr_ok), 0);
        cyc();
        arready = 0;
        #1 chk("t2_inst_retry_ok", 32'(inst_sram_addr_ok), 1);
        cyc();
        inst_sram_req = 0; arready = 1;
        #1 chk("t2_ar2_arvalid", 32'(arvalid), 1);
        chk("t2_ar2_arid", 32'(arid), 0);
        chk("t2_ar2_araddr", araddr, ia);
        cyc();
        arready = 0; rvalid = 1; rid = 0; rdata = r0;
        #1 chk("t2_r0_route", 32'({inst_sram_data_ok, data_sram_data_ok}), 2);
        chk("t2_r0_data", inst_sram_rdata, r0);
        cyc();
        rid = 1; rdata = r1;
        #1 chk("t2_r1_route", 32'({inst_sram_data_ok, data_sram_data_ok}), 1);
        chk("t2_r1_data", data_sram_rdata, r1);
        cyc();
        rvalid = 0;
        #1 chk("t2_quiet", 32'({inst_sram_data_ok, data_sram_data_ok}), 0);

        // Byte store with late awready.
        cyc();
        data_sram_req = 1; data_sram_wr = 1; data_sram_size = 0; data_sram_wstrb = 4'b0100;
        data_sram_addr = 32'h00001002; data_sram_wdata = 32'h00ab0000;
        #1 chk("t3_addr_ok", 32'(data_sram_addr_ok), 1);
        cyc();
        data_sram_req = 0; data_sram_wr = 0; awready = 0; wready = 1;
        #1 chk("t3_awvalid", 32'(awvalid), 1);
        chk("t3_wvalid", 32'(wvalid), 1);
        chk("t3_awsize", 32'(awsize), 0);
        chk("t3_awaddr", awaddr, 32'h00001002);
        chk("t3_wdata", wdata, 32'h00ab0000);
        chk("t3_wstrb", 32'(wstrb), 4);
        chk("t3_wlast", 32'(wlast), 1);
        chk("t3_ids", 32'({awid, wid}), 32'h11);
        cyc();
        wready = 0;
        #1 chk("t3_wvalid_drop", 32'(wvalid), 0);
        chk("t3_awvalid_hold", 32'(awvalid), 1);
        chk("t3_no_early_ok", 32'(data_sram_data_ok), 0);
        cyc();
        awready = 1;
        #1 chk("t3_awvalid_hold2", 32'(awvalid), 1);
        cyc();
        awready = 0;
        #1 chk("t3_awvalid_drop", 32'(awvalid), 0);
        chk("t3_bready", 32'(bready), 1);
        chk("t3_wait_b", 32'(data_sram_data_ok), 0);
        cyc();
        bvalid = 1; bid = 1;
        #1 chk("t3_b_data_ok", 32'(data_sram_data_ok), 1);
        cyc();
        bvalid = 0;
        #1 chk("t3_bready_drop", 32'(bready), 0);

        // Reads held off while a store is in flight.
        ia = {$urandom} & 32'hfffffffc; da = {$urandom} & 32'hfffffffc;
        cyc();
        data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2; data_sram_wstrb = 4'hf;
        data_sram_addr = da; data_sram_wdata = $urandom;
        #1 chk("t4_store_ok", 32'(data_sram_addr_ok), 1);
        cyc();
        data_sram_wr = 0; data_sram_addr = da;
        inst_sram_req = 1; inst_sram_addr = ia; awready = 1; wready = 1;
        #1 chk("t4_blocked_send", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 0);
        cyc();
        awready = 0; wready = 0;
        #1 chk("t4_blocked_resp", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 0);
        cyc();
        bvalid = 1;
        #1 chk("t4_b_ok", 32'(data_sram_data_ok), 1);
        chk("t4_blocked_bcycle", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 0);
        cyc();
        bvalid = 0;
        #1 chk("t4_load_accept", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 1);
        chk("t4_ar_after", 32'(arvalid), 0);
        cyc();
        data_sram_req = 0; arready = 1;
        #1 chk("t4_load_ar", 32'({arvalid, arid}), 32'h11);
        chk("t4_load_araddr", araddr, da);
        cyc();
        arready = 0;
        #1 chk("t4_fetch_accept", 32'(inst_sram_addr_ok), 1);
        cyc();
        inst_sram_req = 0; arready = 1;
        #1 chk("t4_fetch_ar", 32'({arvalid, arid}), 32'h10);
        cyc();
        arready = 0; rvalid = 1; rid = 1;
        #1 chk("t4_load_ok", 32'({inst_sram_data_ok, data_sram_data_ok}), 1);
        cyc();
        rid = 0;
        #1 chk("t4_fetch_ok", 32'({inst_sram_data_ok, data_sram_data_ok}), 2);
        cyc();
        rvalid = 0;

        // Asynchronous reset with a data read outstanding and an inst AR pending.
        da = {$urandom} & 32'hfffffffc;
        cyc();
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = da;
        #1 chk("t5_load_ok", 32'(data_sram_addr_ok), 1);
        cyc();
        data_sram_req = 0; arready = 1;
        cyc();
        arready = 0; inst_sram_req = 1; inst_sram_addr = ia;
        #1 chk("t5_fetch_ok", 32'(inst_sram_addr_ok), 1);
        cyc();
        inst_sram_req = 0;
        #1 chk("t5_ar_req", 32'(arvalid), 1);
        #2 resetn = 0;
        #1 chk("t5_arvalid_async", 32'(arvalid), 0);
        cyc();
        resetn = 1;
        cyc();
        rvalid = 1; rid = 1; rdata = $urandom;
        #1 chk("t5_stale_r_dropped", 32'({inst_sram_data_ok, data_sram_data_ok}), 0);
        chk("t5_arvalid_idle", 32'(arvalid), 0);
        cyc();
        rvalid = 0; data_sram_req = 1; data_sram_addr = da;
        #1 chk("t5_new_accept", 32'(data_sram_addr_ok), 1);
        cyc();
        data_sram_req = 0; arready = 1;
        #1 chk("t5_new_ar", araddr, da);
        cyc();
        arready = 0; rvalid = 1; rid = 1;
        #1 chk("t5_new_data_ok", 32'(data_sram_data_ok), 1);
        cyc();
        rvalid = 0;

        // Random store/load pairs against the two memory views.
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end
        for (int it = 0; it < 14; it++) begin
            wi = 4'($urandom_range(0, 15));
            wsz = 2'($urandom_range(0, 2));
            woff = (wsz == 0) ? 2'($urandom_range(0, 3)) : (wsz == 1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
            ws = (wsz == 0) ? (4'b0001 << woff) : (wsz == 1) ? (4'b0011 << woff) : 4'b1111;
            wd = $urandom;
            do_write(32'h80000000 | {26'd0, wi, woff}, wsz, ws, wd);
            ra = 32'h80000000 | {26'd0, wi, 2'b00};
            do_read(1'($urandom_range(0, 1)), ra);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
